scroll_ctrl: RTL and testbench

//   Upstream control stage for the LED scroller. Synchronises and debounces two

---
 rtl/scroll_ctrl_if.sv | 22 ++
 rtl/scroll_ctrl.sv | 109 ++++++++++
 tb/tb_scroll_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_ctrl_if.sv
// Control bundle between the scroll controller and its neighbours: raw user
// inputs travel in, the step pulse and direction/pause levels travel out.
interface scroll_ctrl_if;
  logic       btn_pause;
  logic       btn_dir;
  logic [1:0] speed_sel;
  logic       step;
  logic       dir;
  logic       paused;

  // Board side: drives the raw buttons/switch, observes the scroll controls.
  modport master (
    output btn_pause, btn_dir, speed_sel,
    input  step, dir, paused
  );

  // Controller side.
  modport slave (
    input  btn_pause, btn_dir, speed_sel,
    output step, dir, paused
  );
endinterface

// File: rtl/scroll_ctrl.sv
// Upstream control stage for the LED scroller. Synchronises and debounces the
// pause/direction buttons, synchronises the speed switch, and emits a one-cycle
// step pulse every (CNT_1S >> speed) cycles unless paused.
module scroll_ctrl #(
  parameter logic [26:0] CNT_1S = 27'd100_000_000,
  parameter logic [19:0] DB_CNT = 20'd1_000_000
) (
  input  logic         clk,
  input  logic         resetn,
  scroll_ctrl_if.slave ctrl
);

  // Button index 0 is pause, index 1 is direction.
  logic [1:0]       btn_s1_q, btn_s2_q;
  logic [1:0]       spd_s1_q, spd_s2_q, spd_prev_q;
  logic [1:0][19:0] db_cnt_q, db_cnt_d;
  logic [1:0]       lvl_q, lvl_d, lvl_prev_q;
  logic [1:0]       rise;
  logic [26:0]      per, cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             paused_q, paused_d;

  // Debounce: a button level is accepted only after it has differed from the
  // current debounced level for DB_CNT consecutive cycles.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    db_cnt_d = db_cnt_q;
    lvl_d    = lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_CNT - 20'd1) begin
          lvl_d[i]    = btn_s2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 20'd1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Rising edges of the debounced levels toggle pause and direction.
  always_comb begin
    rise     = lvl_q & ~lvl_prev_q;
    paused_d = paused_q ^ rise[0];
    dir_d    = dir_q ^ rise[1];
  end

  // Step period generator; a speed change restarts the count, pause freezes it.
  always_comb begin
    per = CNT_1S >> spd_s2_q;
    if (per == '0) begin
      per = 27'd1;
    end
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (paused_q) begin
      cnt_d = cnt_q;
    end else if (spd_s2_q != spd_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == per - 27'd1) begin
      cnt_d  = '0;
      step_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 27'd1;
    end
  end

  // State registers: synchronisers, debounce, edge history, counter, outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      spd_s1_q   <= '0;
      spd_s2_q   <= '0;
      spd_prev_q <= '0;
      db_cnt_q   <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the synchroniser chain would collapse to one stage with blocking ones.
      btn_s1_q   <= {ctrl.btn_dir, ctrl.btn_pause};
      btn_s2_q   <= btn_s1_q;
      spd_s1_q   <= ctrl.speed_sel;
      spd_s2_q   <= spd_s1_q;
      spd_prev_q <= spd_s2_q;
      db_cnt_q   <= db_cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      paused_q   <= paused_d;
    end
  end

  assign ctrl.step   = step_q;
  assign ctrl.dir    = dir_q;
  assign ctrl.paused = paused_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl. Expected step cycles are queued when stimulus is
// applied; a negedge monitor pops and compares whenever a DUT steps.
// dut_a uses CNT_1S=100, dut_b uses CNT_1S=4 for the clamped-period case.
module tb_scroll_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   t0 = 0;
  int   q_a[$];
  int   q_b[$];
  bit   mon_b_en = 1'b0;

  scroll_ctrl_if a_if ();
  scroll_ctrl_if b_if ();

  scroll_ctrl #(.CNT_1S(27'd100), .DB_CNT(20'd4)) dut_a (
    .clk(clk), .resetn(resetn), .ctrl(a_if)
  );

  scroll_ctrl #(.CNT_1S(27'd4), .DB_CNT(20'd4)) dut_b (
    .clk(clk), .resetn(resetn), .ctrl(b_if)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge N has settled, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for dut_a.
  always @(negedge clk) begin
    if (resetn && a_if.step) begin
      n_assert++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL step_a: unexpected step at cycle %0d (rel %0d), none expected", cyc, cyc - t0);
      end else begin
        int exp_c;
        exp_c = q_a.pop_front();
        if (cyc !== exp_c) begin
          n_fail++;
          $display("FAIL step_a: step at rel cycle %0d, expected rel cycle %0d", cyc - t0, exp_c - t0);
        end
      end
    end
  end

  // Scoreboard monitor for dut_b, active only in the clamped-period test.
  always @(negedge clk) begin
    if (resetn && mon_b_en && b_if.step) begin
      n_assert++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL step_b: unexpected step at rel cycle %0d", cyc - t0);
      end else begin
        int exp_c;
        exp_c = q_b.pop_front();
        if (cyc !== exp_c) begin
          n_fail++;
          $display("FAIL step_b: step at rel cycle %0d, expected rel cycle %0d", cyc - t0, exp_c - t0);
        end
      end
    end
  end

  // Advance to 1 ns after posedge number c (no-op if already there).
  task automatic tick_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply reset with idle buttons, release 1 ns after an edge, record t0.
  task automatic do_reset(input logic [1:0] spd);
    resetn = 1'b0;
    a_if.btn_pause = 1'b0;
    a_if.btn_dir   = 1'b0;
    a_if.speed_sel = spd;
    q_a.delete();
    q_b.delete();
    #200;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    t0 = cyc;
  endtask

  task automatic check_q_a_empty(input string name);
    n_assert++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected steps never seen, next at rel cycle %0d", name, q_a.size(), q_a[0] - t0);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    a_if.btn_pause = 1'b0;
    a_if.btn_dir   = 1'b0;
    a_if.speed_sel = 2'd0;
    #100;
    n_assert++;
    if (a_if.step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b expected 0", a_if.step); end
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL rst_dir: got %b expected 0", a_if.dir); end
    n_assert++;
    if (a_if.paused !== 1'b0) begin n_fail++; $display("FAIL rst_paused: got %b expected 0", a_if.paused); end
    do_reset(2'd0);
    q_a.push_back(t0 + 100);
    q_a.push_back(t0 + 200);
    q_a.push_back(t0 + 300);
    tick_to(t0 + 305);
    check_q_a_empty("reset_steps");
  endtask

  task automatic test_speed;
    do_reset(2'd2);
    // Leaving reset, the synchronised speed differs from its zeroed previous
    // copy, so the count restarts at edge 3 and the first 25-cycle step is at 28.
    q_a.push_back(t0 + 28);
    q_a.push_back(t0 + 53);
    // dut_b: 4 >> 3 == 0 clamps to 1; restart at edge 3, then a step every cycle.
    for (int k = 4; k <= 99; k++) q_b.push_back(t0 + k);
    mon_b_en = 1'b1;
    tick_to(t0 + 60);
    a_if.speed_sel = 2'd3;
    // Restart 3 edges after the change (t0+63), then period 12.
    q_a.push_back(t0 + 75);
    q_a.push_back(t0 + 87);
    q_a.push_back(t0 + 99);
    tick_to(t0 + 100);
    mon_b_en = 1'b0;
    check_q_a_empty("speed_steps");
    n_assert++;
    if (q_b.size() != 0) begin
      n_fail++;
      $display("FAIL clamp_steps: %0d expected steps never seen, next at rel cycle %0d", q_b.size(), q_b[0] - t0);
    end
  endtask

  task automatic test_pause;
    do_reset(2'd0);
    tick_to(t0 + 30);
    a_if.btn_pause = 1'b1;
    tick_to(t0 + 36);
    n_assert++;
    if (a_if.paused !== 1'b0) begin n_fail++; $display("FAIL pause_early: paused=%b expected 0", a_if.paused); end
    tick_to(t0 + 37);
    n_assert++;
    if (a_if.paused !== 1'b1) begin n_fail++; $display("FAIL pause_on: paused=%b expected 1", a_if.paused); end
    tick_to(t0 + 40);
    a_if.btn_pause = 1'b0;
    tick_to(t0 + 150);
    n_assert++;
    if (a_if.paused !== 1'b1) begin n_fail++; $display("FAIL pause_hold: paused=%b expected 1", a_if.paused); end
    // Counter froze at 37; 63 counts remain after the resume at t0+157.
    q_a.push_back(t0 + 220);
    q_a.push_back(t0 + 320);
    a_if.btn_pause = 1'b1;
    tick_to(t0 + 156);
    n_assert++;
    if (a_if.paused !== 1'b1) begin n_fail++; $display("FAIL resume_early: paused=%b expected 1", a_if.paused); end
    tick_to(t0 + 157);
    n_assert++;
    if (a_if.paused !== 1'b0) begin n_fail++; $display("FAIL resume: paused=%b expected 0", a_if.paused); end
    tick_to(t0 + 160);
    a_if.btn_pause = 1'b0;
    tick_to(t0 + 325);
    check_q_a_empty("resume_steps");
  endtask

  task automatic test_dir_glitch;
    do_reset(2'd0);
    tick_to(t0 + 5);
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 8);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 25);
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL short_pulse: dir=%b expected 0", a_if.dir); end
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 27);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 29);
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 31);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 45);
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL bounce: dir=%b expected 0", a_if.dir); end
    // A pulse of exactly DB_CNT cycles is accepted.
    tick_to(t0 + 50);
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 54);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 56);
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL min_pulse_early: dir=%b expected 0", a_if.dir); end
    tick_to(t0 + 57);
    n_assert++;
    if (a_if.dir !== 1'b1) begin n_fail++; $display("FAIL min_pulse: dir=%b expected 1", a_if.dir); end
  endtask

  task automatic test_dir_hold;
    do_reset(2'd0);
    for (int k = 1; k <= 10; k++) q_a.push_back(t0 + 100 * k);
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 6);
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL dir_early: dir=%b expected 0", a_if.dir); end
    tick_to(t0 + 7);
    n_assert++;
    if (a_if.dir !== 1'b1) begin n_fail++; $display("FAIL dir_on: dir=%b expected 1", a_if.dir); end
    tick_to(t0 + 500);
    n_assert++;
    if (a_if.dir !== 1'b1) begin n_fail++; $display("FAIL dir_held: dir=%b expected 1", a_if.dir); end
    tick_to(t0 + 1000);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 1030);
    n_assert++;
    if (a_if.dir !== 1'b1) begin n_fail++; $display("FAIL dir_release: dir=%b expected 1", a_if.dir); end
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 1036);
    n_assert++;
    if (a_if.dir !== 1'b1) begin n_fail++; $display("FAIL dir2_early: dir=%b expected 1", a_if.dir); end
    tick_to(t0 + 1037);
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL dir2: dir=%b expected 0", a_if.dir); end
    tick_to(t0 + 1040);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 1050);
    check_q_a_empty("hold_steps");
  endtask

  task automatic test_reset_mid;
    do_reset(2'd0);
    tick_to(t0 + 20);
    a_if.btn_dir = 1'b1;
    tick_to(t0 + 30);
    a_if.btn_dir = 1'b0;
    tick_to(t0 + 33);
    a_if.btn_pause = 1'b1;
    tick_to(t0 + 43);
    a_if.btn_pause = 1'b0;
    tick_to(t0 + 45);
    n_assert++;
    if (a_if.paused !== 1'b1) begin n_fail++; $display("FAIL mid_paused: paused=%b expected 1", a_if.paused); end
    n_assert++;
    if (a_if.dir !== 1'b1) begin n_fail++; $display("FAIL mid_dir: dir=%b expected 1", a_if.dir); end
    #2;
    resetn = 1'b0;
    #1;
    n_assert++;
    if (a_if.paused !== 1'b0) begin n_fail++; $display("FAIL async_paused: paused=%b expected 0", a_if.paused); end
    n_assert++;
    if (a_if.dir !== 1'b0) begin n_fail++; $display("FAIL async_dir: dir=%b expected 0", a_if.dir); end
    n_assert++;
    if (a_if.step !== 1'b0) begin n_fail++; $display("FAIL async_step: step=%b expected 0", a_if.step); end
    #30;
    do_reset(2'd0);
    q_a.push_back(t0 + 100);
    tick_to(t0 + 105);
    check_q_a_empty("post_reset_step");
    n_assert++;
    if (a_if.paused !== 1'b0) begin n_fail++; $display("FAIL post_reset_paused: paused=%b expected 0", a_if.paused); end
  endtask

  initial begin
    resetn = 1'b0;
    b_if.btn_pause = 1'b0;
    b_if.btn_dir   = 1'b0;
    b_if.speed_sel = 2'd3;
    test_reset();
    test_speed();
    test_pause();
    test_dir_glitch();
    test_dir_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
